// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises instruction-fetch and data requests from the
// datapath onto a single-port RAM. It returns one-cycle ihit/dhit pulses with
// registered load data, and a watchdog aborts any RAM access that never
// completes. Data requests always win arbitration over instruction fetches.
module mem_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        ihit,
    output logic        dhit,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ready,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2,
        RESP = 2'd3
    } state_t;

    // Last watchdog value that is still allowed in an access state.
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    state_t      state_r, state_s;
    logic        is_write_r, is_write_s;
    logic [7:0]  wdog_r, wdog_s;
    logic        ihit_s, dhit_s, ramren_s, ramwen_s, err_s;
    logic [31:0] iload_s, dload_s, ramaddr_s, ramstore_s;
    logic        imatch_s, dmatch_s;

    // ramaddr holds the latched word address of the access in flight, so the
    // requester is still "the same request" only if its word address matches.
    assign imatch_s = ((iaddr & WORD_MASK) == ramaddr);
    assign dmatch_s = ((daddr & WORD_MASK) == ramaddr);

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered outputs, access bookkeeping and watchdog.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            is_write_r <= 1'b0;
            wdog_r     <= 8'd0;
            ihit       <= 1'b0;
            dhit       <= 1'b0;
            ramREN     <= 1'b0;
            ramWEN     <= 1'b0;
            ramaddr    <= 32'd0;
            ramstore   <= 32'd0;
            iload      <= 32'd0;
            dload      <= 32'd0;
            mem_err    <= 1'b0;
        end else begin
            is_write_r <= is_write_s;
            wdog_r     <= wdog_s;
            ihit       <= ihit_s;
            dhit       <= dhit_s;
            ramREN     <= ramren_s;
            ramWEN     <= ramwen_s;
            ramaddr    <= ramaddr_s;
            ramstore   <= ramstore_s;
            iload      <= iload_s;
            dload      <= dload_s;
            mem_err    <= err_s;
        end
    end

    // Next-state and next-output logic: arbitration, completion and abort.
    always_comb begin
        state_s    = state_r;
        is_write_s = is_write_r;
        wdog_s     = wdog_r;
        ihit_s     = 1'b0;
        dhit_s     = 1'b0;
        ramren_s   = ramREN;
        ramwen_s   = ramWEN;
        ramaddr_s  = ramaddr;
        ramstore_s = ramstore;
        iload_s    = iload;
        dload_s    = dload;
        err_s      = mem_err;
        case (state_r)
            IDLE: begin
                if (dWEN) begin
                    // A simultaneous dREN is folded into the write.
                    state_s    = DACC;
                    is_write_s = 1'b1;
                    ramren_s   = 1'b0;
                    ramwen_s   = 1'b1;
                    ramaddr_s  = daddr & WORD_MASK;
                    ramstore_s = dstore;
                    wdog_s     = 8'd0;
                end else if (dREN) begin
                    state_s    = DACC;
                    is_write_s = 1'b0;
                    ramren_s   = 1'b1;
                    ramwen_s   = 1'b0;
                    ramaddr_s  = daddr & WORD_MASK;
                    ramstore_s = dstore;
                    wdog_s     = 8'd0;
                end else if (iREN) begin
                    state_s    = IACC;
                    is_write_s = 1'b0;
                    ramren_s   = 1'b1;
                    ramwen_s   = 1'b0;
                    ramaddr_s  = iaddr & WORD_MASK;
                    ramstore_s = dstore;
                    wdog_s     = 8'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            IACC: begin
                if (ram_ready) begin
                    iload_s  = ramload;
                    ihit_s   = iREN && imatch_s;
                    ramren_s = 1'b0;
                    ramwen_s = 1'b0;
                    state_s  = RESP;
                end else if (wdog_r == WDOG_LAST) begin
                    err_s    = 1'b1;
                    ramren_s = 1'b0;
                    ramwen_s = 1'b0;
                    state_s  = IDLE;
                end else begin
                    wdog_s = wdog_r + 8'd1;
                end
            end
            DACC: begin
                if (ram_ready) begin
                    if (is_write_r) begin
                        dhit_s = dWEN && dmatch_s;
                    end else begin
                        dload_s = ramload;
                        dhit_s  = dREN && dmatch_s;
                    end
                    ramren_s = 1'b0;
                    ramwen_s = 1'b0;
                    state_s  = RESP;
                end else if (wdog_r == WDOG_LAST) begin
                    err_s    = 1'b1;
                    ramren_s = 1'b0;
                    ramwen_s = 1'b0;
                    state_s  = IDLE;
                end else begin
                    wdog_s = wdog_r + 8'd1;
                end
            end
            RESP: begin
                // Hit cycle; never accept a new request here.
                state_s = IDLE;
            end
            default: begin
                state_s  = IDLE;
                ramren_s = 1'b0;
                ramwen_s = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Responder side of the pipeline's memory handshake. Accepts instruction-fetch requests (iREN/iaddr) and data requests (dREN/dWEN/daddr/dstore) from the datapath.
- Serialises them onto a single-port RAM and returns one-cycle ihit/dhit pulses with registered load data. The hazard unit consumes these pulses.
- Sits between the datapath/hazard unit and the RAM model. Data requests take priority over instruction fetches.
- Includes a watchdog that aborts a RAM access that never completes.

Parameters:
- TIMEOUT, 64, max cycles spent in an access state waiting for ram_ready before abort (legal range 2..255)

Ports:
- CLK  input  1  system clock, rising edge
- nRST  input  1  asynchronous active-low reset
- iREN  input  1  instruction read request, level, held until ihit
- iaddr  input  32  instruction byte address
- dREN  input  1  data read request, level, held until dhit
- dWEN  input  1  data write request, level, held until dhit
- daddr  input  32  data byte address
- dstore  input  32  data write value
- ihit  output  1  one-cycle pulse: instruction read complete, iload valid
- dhit  output  1  one-cycle pulse: data access complete, dload valid for reads
- iload  output  32  registered instruction word
- dload  output  32  registered data word
- ramREN  output  1  RAM read strobe
- ramWEN  output  1  RAM write strobe
- ramaddr  output  32  RAM word address, {addr[31:2],2'b00}
- ramstore  output  32  RAM write data
- ramload  input  32  RAM read data, valid when ram_ready=1
- ram_ready  input  1  RAM completion, one cycle per access
- mem_err  output  1  sticky: watchdog expired; cleared only by reset

Behaviour:
- Reset (async, nRST=0): state=IDLE. ihit, dhit, ramREN, ramWEN, mem_err = 0. iload, dload, ramaddr, ramstore, watchdog = 0. Reset mid-access abandons the access with no hit.
- FSM states: IDLE, IACC, DACC, RESP.
- IDLE arbitration, evaluated in this order:
  - If dWEN=1, go to DACC as a write. dWEN=1 with dREN=1 is treated as a write.
  - Else if dREN=1, go to DACC as a read.
  - Else if iREN=1, go to IACC.
  - Else stay in IDLE.
  - On entry, latch op, word address (bits [1:0] forced 0), dstore and the request's source. Clear the watchdog.
- IACC/DACC:
  - ramREN/ramWEN/ramaddr/ramstore are registered and asserted for every cycle of the state.
  - Exactly one of ramREN/ramWEN is high.
  - Watchdog increments each cycle.
- ram_ready=1 in an access state:
  - Capture ramload into iload (IACC) or dload (DACC read). dload is unchanged on writes.
  - Deassert RAM strobes and go to RESP.
  - Set ihit/dhit for RESP only if the originating request is still asserted with an identical word address. A write also requires dWEN still high.
  - Otherwise the result is discarded silently: the load register still updates and no hit is issued.
- Watchdog == TIMEOUT-1 with no ram_ready: set mem_err, drop strobes, go to IDLE, no hit.
- RESP: exactly one cycle with the hit high (or no hit if discarded), then IDLE. No new request is accepted in RESP.
- Latency: a request seen in IDLE at cycle 0 puts strobes high at cycle 1. ram_ready at cycle k≥1 gives the hit at cycle k+1. Minimum request-to-hit is 2 cycles; minimum spacing between accesses is 3 cycles.
- ihit and dhit are never high in the same cycle.
- A request arriving during IACC/DACC/RESP waits in IDLE arbitration. A pending dREN/dWEN beats a pending iREN, so an instruction fetch can starve while data requests persist; the hazard unit relies on this ordering.
- ram_ready in IDLE/RESP is ignored.

Test Plan:
- Reset, then iREN=1, iaddr=0x0000_0043; RAM returns 0x2401_0005 with ram_ready at cycle 1 -> ramaddr=0x0000_0040 with ramREN=1 at cycle 1; ihit=1 and iload=0x2401_0005 at cycle 2 only; dhit stays 0.
- iREN=1 and dREN=1 together, daddr=0x100, ramload=0xDEAD_BEEF -> data served first: dhit and dload=0xDEADBEEF; then the instruction access starts, with ihit at least 3 cycles after dhit.
- dWEN=1, daddr=0x200, dstore=0x1234_5678, ram_ready delayed 5 cycles -> ramWEN=1, ramstore=0x12345678 held for 5 cycles; dhit pulses once; dload unchanged.
- iREN dropped (flush) during IACC before ram_ready -> access completes, iload updates, ihit stays 0, FSM returns to IDLE.
- TIMEOUT=8, ram_ready never asserted -> strobes drop after 8 access cycles; mem_err=1 and stays 1; no hit; next request is still serviced.
- nRST pulsed low mid-DACC -> all outputs 0 immediately (asynchronously); no dhit after release.
